// File: rtl/fx_expand_pipe_if.sv
// Stream bundle for the fixed-point expander: input sample handshake,
// output sample handshake, flush and transfer counter.
interface fx_expand_pipe_if #(
    parameter int IW    = 13,
    parameter int OW    = 14,
    parameter int CNT_W = 16
);
    logic [IW-1:0]    i_data;
    logic             i_valid;
    logic             o_ready;
    logic [OW-1:0]    o_data;
    logic             o_valid;
    logic             i_ready;
    logic             i_flush;
    logic [CNT_W-1:0] o_count;

    modport master (
        output i_data, i_valid, i_ready, i_flush,
        input  o_ready, o_data, o_valid, o_count
    );

    modport slave (
        input  i_data, i_valid, i_ready, i_flush,
        output o_ready, o_data, o_valid, o_count
    );
endinterface

// File: rtl/fx_expand_pipe.sv
// Narrow-to-wide fixed-point expander (sign/zero extend, LSB pad)
// behind a collapsing valid/ready register chain with flush and counter.
module fx_expand_pipe #(
    parameter int IW      = 13,
    parameter int OW      = 14,
    parameter int LSB_PAD = 0,
    parameter int SIGNED  = 1,
    parameter int DELAY   = 4,
    parameter int CNT_W   = 16
) (
    input logic clk,
    input logic rst_n,
    fx_expand_pipe_if.slave bus
);
    localparam int EW = OW - LSB_PAD;

    if (OW < IW + LSB_PAD) begin : g_bad_width
        $error("fx_expand_pipe: OW must be >= IW + LSB_PAD");
    end
    if (DELAY < 1) begin : g_bad_delay
        $error("fx_expand_pipe: DELAY must be >= 1");
    end

    logic [EW-1:0]    ext;
    logic [OW-1:0]    res;
    logic [DELAY-1:0] vld;
    logic [OW-1:0]    dat [DELAY];
    logic [DELAY-1:0] load;
    logic [CNT_W-1:0] cnt;
    logic             out_xfer;

    always_comb begin
        if (SIGNED != 0) ext = EW'($signed(bus.i_data));
        else             ext = EW'(bus.i_data);
        res = OW'(ext) << LSB_PAD;
    end

    // A stage can load whenever the sink is ready or some stage at or
    // downstream of it is empty; this is what collapses bubbles.
    always_comb begin
        logic full;
        full = 1'b1;
        load = '0;
        for (int k = DELAY - 1; k >= 0; k--) begin
            full    = full & vld[k];
            load[k] = bus.i_ready | ~full;
        end
    end

    assign out_xfer    = vld[DELAY-1] & bus.i_ready;
    assign bus.o_ready = load[0] & ~bus.i_flush;
    assign bus.o_valid = vld[DELAY-1];
    assign bus.o_data  = dat[DELAY-1];
    assign bus.o_count = cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            cnt <= '0;
            for (int k = 0; k < DELAY; k++) dat[k] <= '0;
        end else if (bus.i_flush) begin
            vld <= '0;
            cnt <= '0;
        end else begin
            if (out_xfer) cnt <= cnt + CNT_W'(1);
            if (load[0]) vld[0] <= bus.i_valid;
            if (load[0] && bus.i_valid) dat[0] <= res;
            for (int k = 1; k < DELAY; k++) begin
                if (load[k]) vld[k] <= vld[k-1];
                if (load[k] && vld[k-1]) dat[k] <= dat[k-1];
            end
        end
    end
endmodule
